// File: rtl/tdc_pkg.sv
// Shared TDC controller types: FSM state encoding and TDC word width.
// No logic here; imported by the controller and its calibration averager.
package tdc_pkg;

  localparam int TDC_W    = 12;
  localparam int RSTP_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RSTP,
    ST_SETTLE,
    ST_CAL,
    ST_RUN
  } tdc_state_t;

endpackage

// File: rtl/tdc_cal_avg.sv
// Calibration averager: sums 2^CAL_LOG2 strobed samples, then registers the truncated mean.
// Mean and done update on the edge of the final sample; no backpressure, clr wins over smp.
module tdc_cal_avg
  import tdc_pkg::*;
#(
  parameter int CAL_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             smp,
  input  logic [TDC_W-1:0] din,
  output logic             last,
  output logic             done,
  output logic [TDC_W-1:0] mean
);

  localparam int ACC_W = TDC_W + CAL_LOG2;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [CAL_LOG2-1:0] cnt;

  // Sized so 2^CAL_LOG2 samples of full-scale cannot overflow.
  assign sum  = acc + ACC_W'(din);
  assign last = smp && (cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
      mean <= '0;
    end else if (clr) begin
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (smp) begin
      if (cnt == '1) begin
        mean <= TDC_W'(sum >> CAL_LOG2);
        done <= 1'b1;
        acc  <= '0;
        cnt  <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_ctrl.sv
// TDC session controller: reset pulse, settle, calibrate (mean word), then stream words.
// All outputs registered; stop > recal > start, requests outside their state are dropped.
module tdc_ctrl
  import tdc_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int CAL_LOG2   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             recal,
  input  logic [TDC_W-1:0] tdc_word,
  output logic             tdc_rst,
  output logic             tdc_en,
  output logic [TDC_W-1:0] word_out,
  output logic             word_valid,
  output logic [TDC_W-1:0] period_avg,
  output logic             cal_done,
  output logic             busy
);

  tdc_state_t state;
  logic [7:0] cnt;
  logic       cal_clr;
  logic       cal_smp;
  logic       cal_last;

  // Accumulator is cleared on the edge that enters CAL; a stop abandons the last sample.
  assign cal_clr = !stop &&
                   (((state == ST_SETTLE) && (cnt == 8'(SETTLE_CYC - 1))) ||
                    ((state == ST_RUN) && recal));
  assign cal_smp = (state == ST_CAL) && !stop;

  tdc_cal_avg #(
    .CAL_LOG2(CAL_LOG2)
  ) u_cal_avg (
    .clk (clk),
    .rst (rst),
    .clr (cal_clr),
    .smp (cal_smp),
    .din (tdc_word),
    .last(cal_last),
    .done(cal_done),
    .mean(period_avg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tdc_rst    <= 1'b1;
      tdc_en     <= 1'b0;
      busy       <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (stop && (state != ST_IDLE)) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tdc_rst    <= 1'b1;
      tdc_en     <= 1'b0;
      busy       <= 1'b0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state <= ST_RSTP;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_RSTP: begin
          if (cnt == 8'(RSTP_CYC - 1)) begin
            state   <= ST_SETTLE;
            cnt     <= '0;
            tdc_rst <= 1'b0;
            tdc_en  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt == 8'(SETTLE_CYC - 1)) begin
            state <= ST_CAL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_CAL: begin
          if (cal_last) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (recal) begin
            state <= ST_CAL;
          end else begin
            word_out   <= tdc_word;
            word_valid <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          tdc_rst <= 1'b1;
          tdc_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_ctrl.sv
// Directed bench for tdc_ctrl: cycle table for a full session plus reset and wide-average sequences.
module tb_tdc_ctrl;

  logic        clk;
  logic        rst;
  logic        start, stop, recal;
  logic [11:0] tdc_word;
  logic        tdc_rst, tdc_en, word_valid, cal_done, busy;
  logic [11:0] word_out, period_avg;

  logic        start8;
  logic [11:0] tdc_word8;
  logic        tdc_rst8, tdc_en8, word_valid8, cal_done8, busy8;
  logic [11:0] word_out8, period_avg8;

  int checks = 0;
  int errors = 0;

  tdc_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .recal(recal),
    .tdc_word(tdc_word), .tdc_rst(tdc_rst), .tdc_en(tdc_en),
    .word_out(word_out), .word_valid(word_valid), .period_avg(period_avg),
    .cal_done(cal_done), .busy(busy)
  );

  tdc_ctrl #(.SETTLE_CYC(2), .CAL_LOG2(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .stop(1'b0), .recal(1'b0),
    .tdc_word(tdc_word8), .tdc_rst(tdc_rst8), .tdc_en(tdc_en8),
    .word_out(word_out8), .word_valid(word_valid8), .period_avg(period_avg8),
    .cal_done(cal_done8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        stop;
    logic        recal;
    logic [11:0] word;
    logic        e_rst;
    logic        e_en;
    logic        e_busy;
    logic        e_wv;
    logic [11:0] e_wo;
    logic        e_cd;
    logic [11:0] e_pa;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic p, input logic r, input logic [11:0] w,
                     input logic er, input logic ee, input logic eb, input logic ev,
                     input logic [11:0] ewo, input logic ecd, input logic [11:0] epa);
    vec_t v;
    v.start = s; v.stop = p; v.recal = r; v.word = w;
    v.e_rst = er; v.e_en = ee; v.e_busy = eb; v.e_wv = ev;
    v.e_wo = ewo; v.e_cd = ecd; v.e_pa = epa;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " tdc_rst"}, 32'(tdc_rst), 32'd1);
    check({tag, " tdc_en"}, 32'(tdc_en), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " word_valid"}, 32'(word_valid), 32'd0);
    check({tag, " word_out"}, 32'(word_out), 32'd0);
    check({tag, " period_avg"}, 32'(period_avg), 32'd0);
    check({tag, " cal_done"}, 32'(cal_done), 32'd0);
  endtask

  initial begin
    int n;
    logic [28:0] got, want;
    rst = 1'b0; start = 1'b0; stop = 1'b0; recal = 1'b0; tdc_word = '0;
    start8 = 1'b0; tdc_word8 = 12'd4095;

    // Full session: rstp, settle, cal(100), run, recal(200), recal(100/101), stop+recal, aborted cal.
    add(1,0,0,0,   1,0,1,0, 0,0,0);
    add(0,0,0,0,   1,0,1,0, 0,0,0);
    add(0,0,0,0,   0,1,1,0, 0,0,0);
    add(1,0,0,0,   0,1,1,0, 0,0,0);
    add(0,0,1,0,   0,1,1,0, 0,0,0);
    add(0,0,0,0,   0,1,1,0, 0,0,0);
    add(0,0,0,999, 0,1,1,0, 0,0,0);
    for (int i = 0; i < 15; i++)
      add((i == 3), 0, (i == 5), 100, 0,1,1,0, 0,0,0);
    add(0,0,0,100, 0,1,1,0, 0,1,100);
    add(0,0,0,300, 0,1,1,1, 300,1,100);
    add(0,0,0,301, 0,1,1,1, 301,1,100);
    add(0,0,1,200, 0,1,1,0, 301,0,100);
    for (int i = 0; i < 15; i++)
      add(0,0,0,200, 0,1,1,0, 301,0,100);
    add(0,0,0,200, 0,1,1,0, 301,1,200);
    add(0,0,0,7,   0,1,1,1, 7,1,200);
    add(0,0,1,100, 0,1,1,0, 7,0,200);
    for (int i = 0; i < 15; i++)
      add(0,0,0, (i % 2 == 0) ? 12'd100 : 12'd101, 0,1,1,0, 7,0,200);
    add(0,0,0,101, 0,1,1,0, 7,1,100);
    add(0,1,1,55,  1,0,0,0, 7,1,100);
    add(0,0,0,0,   1,0,0,0, 7,1,100);
    add(1,0,0,0,   1,0,1,0, 7,1,100);
    add(0,0,0,0,   1,0,1,0, 7,1,100);
    for (int i = 0; i < 4; i++)
      add(0,0,0,0, 0,1,1,0, 7,1,100);
    add(0,0,0,4000, 0,1,1,0, 7,0,100);
    for (int i = 0; i < 5; i++)
      add(0,0,0,4000, 0,1,1,0, 7,0,100);
    add(0,1,0,4000, 1,0,0,0, 7,0,100);
    add(0,0,0,0,    1,0,0,0, 7,0,100);

    // Reset values appear before any clock edge.
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    tick;
    tick;
    rst = 1'b0;
    tick;
    tick;
    check("idle after rst busy", 32'(busy), 32'd0);
    check("idle after rst tdc_rst", 32'(tdc_rst), 32'd1);

    foreach (vecs[i]) begin
      start = vecs[i].start; stop = vecs[i].stop; recal = vecs[i].recal;
      tdc_word = vecs[i].word;
      tick;
      got  = {tdc_rst, tdc_en, busy, word_valid, cal_done, word_out, period_avg};
      want = {vecs[i].e_rst, vecs[i].e_en, vecs[i].e_busy, vecs[i].e_wv, vecs[i].e_cd,
              vecs[i].e_wo, vecs[i].e_pa};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL row%0d: got rst=%b en=%b busy=%b wv=%b cd=%b wo=%0d pa=%0d, expected rst=%b en=%b busy=%b wv=%b cd=%b wo=%0d pa=%0d",
                 i, tdc_rst, tdc_en, busy, word_valid, cal_done, word_out, period_avg,
                 vecs[i].e_rst, vecs[i].e_en, vecs[i].e_busy, vecs[i].e_wv, vecs[i].e_cd,
                 vecs[i].e_wo, vecs[i].e_pa);
      end
    end
    start = 1'b0; stop = 1'b0; recal = 1'b0;

    // 256-sample calibration at full scale: no overflow, done exactly after 2+2+256 cycles.
    check("dut8 idle", 32'(busy8), 32'd0);
    start8 = 1'b1;
    tick;
    start8 = 1'b0;
    n = 1;
    while (!cal_done8 && n < 400) begin
      tick;
      n++;
    end
    check("dut8 cal_done", 32'(cal_done8), 32'd1);
    check("dut8 latency", 32'(n), 32'd261);
    check("dut8 period_avg", 32'(period_avg8), 32'd4095);
    check("dut8 word_valid", 32'(word_valid8), 32'd0);

    // Asynchronous reset in the middle of a calibration.
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    check("pre-rst in CAL busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midcal");
    check("midcal dut8 cal_done", 32'(cal_done8), 32'd0);
    tick;
    rst = 1'b0;
    repeat (3) tick;
    check("post-rst idle busy", 32'(busy), 32'd0);
    check("post-rst idle tdc_en", 32'(tdc_en), 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("restart busy", 32'(busy), 32'd1);
    check("restart tdc_rst", 32'(tdc_rst), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_ctrl.md
TDC_CTRL -- requirements
Module: tdc_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4, number of tdc_word samples discarded after enable (range 2..255).
REQ-002 SHALL have parameter CAL_LOG2, default 4, log2 of number of tdc_word samples averaged during calibration (range 1..8).
REQ-003 clk  input  1  reference clock; all controller state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a measurement session.
REQ-006 stop  input  1  single-cycle request to end the session.
REQ-007 recal  input  1  single-cycle request to recalibrate while running.
REQ-008 tdc_word  input  12  TDC output word, sampled on rising clk.
REQ-009 tdc_rst  output  1  reset drive to the TDC digital core.
REQ-010 tdc_en  output  1  enable drive to the TDC digital core.
REQ-011 word_out  output  12  registered copy of tdc_word, updated only in RUN.
REQ-012 word_valid  output  1  high for one cycle per word_out update.
REQ-013 period_avg  output  12  calibrated mean tdc_word.
REQ-014 cal_done  output  1  high while period_avg holds a result from a completed calibration.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, RSTP, SETTLE, CAL, RUN.
REQ-017 IDLE: tdc_en=0, tdc_rst=1; start -> RSTP.
REQ-018 RSTP: tdc_rst=1, tdc_en=0 for exactly 2 cycles, then -> SETTLE.
REQ-019 SETTLE: tdc_rst=0, tdc_en=1; counts SETTLE_CYC cycles, tdc_word ignored; then -> CAL.
REQ-020 CAL: tdc_en=1; accumulates 2^CAL_LOG2 consecutive tdc_word samples into an unsigned (12+CAL_LOG2)-bit accumulator cleared on CAL entry; on the last sample, period_avg <= full sum >> CAL_LOG2 (truncate), cal_done <= 1, -> RUN.
REQ-021 On CAL entry cal_done SHALL clear to 0; period_avg holds its previous value until overwritten.
REQ-022 RUN: tdc_en=1; every cycle word_out <= tdc_word, word_valid <= 1 (first valid one cycle after RUN entry).
REQ-023 RUN with recal -> CAL (word_valid 0 from next cycle); RUN with stop -> IDLE.
REQ-024 stop in any non-IDLE state SHALL return to IDLE next cycle, abandoning any calibration in progress (period_avg unchanged, cal_done stays 0 if cleared).
REQ-025 Priority for simultaneous requests: stop > recal > start.
REQ-026 start while busy and recal outside RUN SHALL be ignored.
REQ-027 Accumulator SHALL never overflow: width sized for 2^CAL_LOG2 samples of 4095.
REQ-028 Counters SHALL saturate/reload, never wrap, in SETTLE and CAL.

Reset
REQ-029 On rst: state=IDLE, tdc_rst=1, tdc_en=0, word_out=0, word_valid=0, period_avg=0, cal_done=0, accumulator and counters=0.
REQ-030 rst assertion mid-session SHALL take effect immediately (asynchronously) on all outputs.
REQ-031 After rst deassert the block SHALL remain IDLE until start.

Structure
REQ-032 State encoding enum and TDC word width (12) SHALL live in shared package tdc_pkg.
REQ-033 Calibration accumulator/averager SHALL be one sub-module tdc_cal_avg (clear, sample strobe, done, mean).
REQ-034 Outputs SHALL be registered; no combinational path from tdc_word to any output.

Verification
REQ-035 rst then start at cycle 0 -> tdc_rst high cycles 1-2, tdc_en rises cycle 3, CAL entered after 4 SETTLE cycles.
REQ-036 Default params, tdc_word constant 100 in CAL -> period_avg=100, cal_done=1 after 16 CAL samples; words 100,101 alternating -> period_avg=100.
REQ-037 tdc_word=4095 for all CAL samples with CAL_LOG2=8 -> period_avg=4095, no overflow.
REQ-038 In RUN, stop and recal same cycle -> IDLE, tdc_en=0, tdc_rst=1 next cycle, word_valid=0.
REQ-039 recal in RUN with words 200 -> cal_done drops, word_valid 0 for 16 cycles, period_avg=200 then RUN resumes.
REQ-040 rst asserted mid-CAL -> all outputs at reset values without waiting for clk; start ignored while busy.
